nios_ocimem_access_ctrl: RTL and testbench

Arbiter and sequencer for the on-chip debug memory (OCI RAM) in the Nios II JTAG debug module. It shares one single-port RAM between two requesters. The first is the host-side JTAG command stream: the sysclk-domain take_action/take_no_action strobes plus jdo. The second is the CPU debug slave, an Avalon-MM port with waitrequest. For the JTAG side it keeps an auto-incrementing address pointer, captures read data into MonDReg and raises monitor_ready.

---
 rtl/nios_ocimem_access_ctrl_pkg.sv | 31 +++
 rtl/nios_ocimem_access_ctrl_if.sv | 22 ++
 rtl/nios_ocimem_access_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_nios_ocimem_access_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nios_ocimem_access_ctrl_pkg.sv
// Shared definitions for the OCI RAM access controller: FSM states,
// jdo field positions, grant encoding and the round-robin pick helper.
package nios_ocimem_access_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_J_RD      = 3'd1,
        ST_J_RD_CAP  = 3'd2,
        ST_J_WR      = 3'd3,
        ST_C_RD      = 3'd4,
        ST_C_RD_DONE = 3'd5,
        ST_C_WR      = 3'd6
    } state_e;

    localparam int JDO_W         = 38;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_WDATA_LSB = 3;
    localparam int JDO_WDATA_MSB = 34;

    localparam logic GRANT_CPU  = 1'b0;
    localparam logic GRANT_JTAG = 1'b1;

    // JTAG wins when it is the only requester, or when both request and
    // the CPU was granted last time.
    function automatic logic pick_jtag(input logic jtag_req,
                                       input logic cpu_req,
                                       input logic last_grant);
        return jtag_req & (~cpu_req | (last_grant == GRANT_CPU));
    endfunction

endpackage

// File: rtl/nios_ocimem_access_ctrl_if.sv
// Avalon-MM CPU debug slave bus into the OCI RAM access controller.
interface nios_ocimem_access_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_address;
    logic              cpu_read;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_writedata;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_waitrequest;

    modport master (
        output cpu_address, cpu_read, cpu_write, cpu_writedata,
        input  cpu_readdata, cpu_waitrequest
    );

    modport slave (
        input  cpu_address, cpu_read, cpu_write, cpu_writedata,
        output cpu_readdata, cpu_waitrequest
    );
endinterface

// File: rtl/nios_ocimem_access_ctrl.sv
// Arbiter/sequencer sharing the single-port OCI RAM between the JTAG
// command stream (auto-incrementing pointer, MonDReg capture) and the
// CPU debug slave. Round-robin when both request in the same IDLE cycle.
module nios_ocimem_access_ctrl
    import nios_ocimem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [JDO_W-1:0]  jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    nios_ocimem_access_ctrl_if.slave cpu,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_rden,
    output logic              ram_wren,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    state_e            r_state;
    logic [ADDR_W-1:0] r_jtag_addr;
    logic              r_pend_valid;
    logic              r_pend_wr;
    logic [DATA_W-1:0] r_pend_wdata;
    logic              r_last_grant;
    logic [ADDR_W-1:0] r_ram_address;
    logic              r_ram_rden;
    logic              r_ram_wren;
    logic [DATA_W-1:0] r_ram_wdata;
    logic [DATA_W-1:0] r_mon_dreg;
    logic              r_monitor_ready;
    logic              r_overrun;

    logic              w_strobe_a;
    logic              w_strobe_b;
    logic              w_strobe_r;
    logic              w_accept;
    logic              w_drop;
    logic              w_jtag_req;
    logic              w_jtag_wr;
    logic [DATA_W-1:0] w_jtag_wdata;
    logic [DATA_W-1:0] w_jdo_wdata;
    logic [ADDR_W-1:0] w_jdo_addr;
    logic              w_cpu_req;
    logic              w_grant_jtag;
    logic              w_cpu_done;
    logic              w_unused_jdo;

    // Strobe priority: address load masks write, write masks read.
    assign w_strobe_a   = take_action_ocimem_a;
    assign w_strobe_b   = ~take_action_ocimem_a & take_action_ocimem_b;
    assign w_strobe_r   = ~take_action_ocimem_a & ~take_action_ocimem_b & take_no_action_ocimem_a;

    // The pending flag stays set while the command is active, so a busy
    // JTAG side drops any further read/write strobe.
    assign w_accept     = (w_strobe_b | w_strobe_r) & ~r_pend_valid;
    assign w_drop       = (w_strobe_b | w_strobe_r) &  r_pend_valid;

    assign w_jdo_addr   = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign w_jdo_wdata  = jdo[JDO_WDATA_LSB +: DATA_W];
    assign w_unused_jdo = ^{jdo[JDO_W-1:JDO_WDATA_MSB+1], jdo[JDO_WDATA_LSB-1:0]};

    // A fresh strobe is visible to the arbiter in its own cycle so an
    // uncontended JTAG write reaches the RAM one cycle after the strobe.
    assign w_jtag_req   = r_pend_valid | w_accept;
    assign w_jtag_wr    = r_pend_valid ? r_pend_wr    : w_strobe_b;
    assign w_jtag_wdata = r_pend_valid ? r_pend_wdata : w_jdo_wdata;

    assign w_cpu_req    = cpu.cpu_read | cpu.cpu_write;
    assign w_grant_jtag = pick_jtag(w_jtag_req, w_cpu_req, r_last_grant);
    assign w_cpu_done   = (r_state == ST_C_WR) | (r_state == ST_C_RD_DONE);

    assign cpu.cpu_waitrequest = w_cpu_req & ~w_cpu_done;
    assign cpu.cpu_readdata    = (r_state == ST_C_RD_DONE) ? ram_rdata : {DATA_W{1'b0}};

    assign ram_address   = r_ram_address;
    assign ram_rden      = r_ram_rden;
    assign ram_wren      = r_ram_wren;
    assign ram_wdata     = r_ram_wdata;
    assign MonDReg       = r_mon_dreg;
    assign monitor_ready = r_monitor_ready;
    assign jtag_overrun  = r_overrun;

    // Arbitration FSM, RAM strobes and JTAG command bookkeeping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= ST_IDLE;
            r_jtag_addr     <= {ADDR_W{1'b0}};
            r_pend_valid    <= 1'b0;
            r_pend_wr       <= 1'b0;
            r_pend_wdata    <= {DATA_W{1'b0}};
            r_last_grant    <= GRANT_CPU;
            r_ram_address   <= {ADDR_W{1'b0}};
            r_ram_rden      <= 1'b0;
            r_ram_wren      <= 1'b0;
            r_ram_wdata     <= {DATA_W{1'b0}};
            r_mon_dreg      <= {DATA_W{1'b0}};
            r_monitor_ready <= 1'b0;
            r_overrun       <= 1'b0;
        end else begin
            r_ram_rden <= 1'b0;
            r_ram_wren <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (w_grant_jtag) begin
                        r_last_grant  <= GRANT_JTAG;
                        r_ram_address <= r_jtag_addr;
                        if (w_jtag_wr) begin
                            r_ram_wren  <= 1'b1;
                            r_ram_wdata <= w_jtag_wdata;
                            r_state     <= ST_J_WR;
                        end else begin
                            r_ram_rden  <= 1'b1;
                            r_state     <= ST_J_RD;
                        end
                    end else if (w_cpu_req) begin
                        r_last_grant  <= GRANT_CPU;
                        r_ram_address <= cpu.cpu_address;
                        if (cpu.cpu_read) begin
                            r_ram_rden  <= 1'b1;
                            r_state     <= ST_C_RD;
                        end else begin
                            r_ram_wren  <= 1'b1;
                            r_ram_wdata <= cpu.cpu_writedata;
                            r_state     <= ST_C_WR;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_J_WR: begin
                    r_jtag_addr     <= r_jtag_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    r_monitor_ready <= 1'b1;
                    r_pend_valid    <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                ST_J_RD: begin
                    r_state <= ST_J_RD_CAP;
                end
                ST_J_RD_CAP: begin
                    r_mon_dreg      <= ram_rdata;
                    r_jtag_addr     <= r_jtag_addr + {{(ADDR_W-1){1'b0}}, 1'b1};
                    r_monitor_ready <= 1'b1;
                    r_pend_valid    <= 1'b0;
                    r_state         <= ST_IDLE;
                end
                ST_C_RD: begin
                    r_state <= ST_C_RD_DONE;
                end
                ST_C_RD_DONE: begin
                    r_state <= ST_IDLE;
                end
                ST_C_WR: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            // Placed after the FSM so an address load overrides a
            // same-cycle post-access increment.
            if (w_strobe_a) begin
                r_jtag_addr     <= w_jdo_addr;
                r_monitor_ready <= 1'b1;
                r_overrun       <= 1'b0;
            end else if (w_accept) begin
                r_pend_valid    <= 1'b1;
                r_pend_wr       <= w_strobe_b;
                r_pend_wdata    <= w_jdo_wdata;
                r_monitor_ready <= 1'b0;
            end else if (w_drop) begin
                r_overrun       <= 1'b1;
            end else begin
                r_overrun       <= r_overrun;
            end
        end
    end

endmodule

// File: tb/tb_nios_ocimem_access_ctrl.sv
// Directed self-checking bench for nios_ocimem_access_ctrl with a
// 1-cycle-latency single-port RAM model.
module tb_nios_ocimem_access_ctrl;

    logic        clk;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic [7:0]  ram_address;
    logic        ram_rden;
    logic        ram_wren;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        jtag_overrun;

    logic [31:0] mem [0:255];
    int          n_wr;
    int          n_rd;
    logic        both_seen;
    int          n_cmp;
    int          n_err;
    int          w0;
    int          r0;

    nios_ocimem_access_ctrl_if #(.ADDR_W(8), .DATA_W(32)) cpu_if ();

    nios_ocimem_access_ctrl #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu                     (cpu_if),
        .ram_address             (ram_address),
        .ram_rden                (ram_rden),
        .ram_wren                (ram_wren),
        .ram_wdata               (ram_wdata),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model plus access counters.
    initial begin
        n_wr = 0;
        n_rd = 0;
        both_seen = 1'b0;
        ram_rdata = 32'h0;
    end
    always @(posedge clk) begin
        if (ram_wren) begin
            mem[ram_address] <= ram_wdata;
            n_wr <= n_wr + 1;
        end
        if (ram_rden) begin
            ram_rdata <= mem[ram_address];
            n_rd <= n_rd + 1;
        end
        if (ram_rden && ram_wren) both_seen <= 1'b1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        assert (obs === exp) else begin
            n_err = n_err + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a(input logic [7:0] a);
        logic [37:0] v;
        v = 38'h0;
        v[24:17] = a;
        jdo = v;
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic pulse_b(input logic [31:0] d);
        logic [37:0] v;
        v = 38'h0;
        v[34:3] = d;
        jdo = v;
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic pulse_r();
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
    endtask

    task automatic cpu_wr(input logic [7:0] a, input logic [31:0] d);
        cpu_if.cpu_address   = a;
        cpu_if.cpu_writedata = d;
        cpu_if.cpu_write     = 1'b1;
        #1 chk("cpu_wr_wait_c0", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        @(negedge clk);
        chk("cpu_wr_wait_c1", {31'h0, cpu_if.cpu_waitrequest}, 32'h0);
        chk("cpu_wr_wren", {31'h0, ram_wren}, 32'h1);
        chk("cpu_wr_addr", {24'h0, ram_address}, {24'h0, a});
        chk("cpu_wr_wdata", ram_wdata, d);
        cpu_if.cpu_write = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset_n = 1'b0;
        jdo = 38'h0;
        take_action_ocimem_a = 1'b0;
        take_action_ocimem_b = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        cpu_if.cpu_address   = 8'h0;
        cpu_if.cpu_read      = 1'b0;
        cpu_if.cpu_write     = 1'b0;
        cpu_if.cpu_writedata = 32'h0;
        repeat (2) @(negedge clk);

        // Reset state
        chk("rst_rden", {31'h0, ram_rden}, 32'h0);
        chk("rst_wren", {31'h0, ram_wren}, 32'h0);
        chk("rst_addr", {24'h0, ram_address}, 32'h0);
        chk("rst_mon", MonDReg, 32'h0);
        chk("rst_ready", {31'h0, monitor_ready}, 32'h0);
        chk("rst_ovr", {31'h0, jtag_overrun}, 32'h0);
        chk("rst_wait", {31'h0, cpu_if.cpu_waitrequest}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);

        // Preload RAM through the CPU port
        cpu_wr(8'h11, 32'h12345678);
        cpu_wr(8'h12, 32'hCAFEF00D);
        cpu_wr(8'h20, 32'hA5A50020);
        cpu_wr(8'h00, 32'h00001111);
        cpu_wr(8'h02, 32'h22222222);

        // 1: load address then write
        pulse_a(8'h10);
        chk("t1_ready_after_load", {31'h0, monitor_ready}, 32'h1);
        chk("t1_no_wren_on_load", {31'h0, ram_wren}, 32'h0);
        pulse_b(32'hDEADBEEF);
        chk("t1_wren", {31'h0, ram_wren}, 32'h1);
        chk("t1_addr", {24'h0, ram_address}, 32'h10);
        chk("t1_wdata", ram_wdata, 32'hDEADBEEF);
        chk("t1_ready_cleared", {31'h0, monitor_ready}, 32'h0);
        @(negedge clk);
        chk("t1_ready_set", {31'h0, monitor_ready}, 32'h1);
        chk("t1_mem10", mem[8'h10], 32'hDEADBEEF);

        // 2: auto-increment reads at 0x11, 0x12, then a write at 0x13
        pulse_r();
        chk("t2_rden_a", {31'h0, ram_rden}, 32'h1);
        chk("t2_addr_a", {24'h0, ram_address}, 32'h11);
        chk("t2_ready_clr", {31'h0, monitor_ready}, 32'h0);
        @(negedge clk);
        @(negedge clk);
        chk("t2_mon_a", MonDReg, 32'h12345678);
        chk("t2_ready_a", {31'h0, monitor_ready}, 32'h1);
        pulse_r();
        chk("t2_addr_b", {24'h0, ram_address}, 32'h12);
        @(negedge clk);
        @(negedge clk);
        chk("t2_mon_b", MonDReg, 32'hCAFEF00D);
        pulse_b(32'h13131313);
        chk("t2_addr_next", {24'h0, ram_address}, 32'h13);
        @(negedge clk);

        // 3: contention right after reset -> JTAG first
        reset_n = 1'b0;
        #1 chk("t3_rst_ready", {31'h0, monitor_ready}, 32'h0);
        chk("t3_rst_mon", MonDReg, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        cpu_if.cpu_address = 8'h20;
        cpu_if.cpu_read    = 1'b1;
        #1 chk("t3_wait_c0", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        chk("t3_jrd_rden", {31'h0, ram_rden}, 32'h1);
        chk("t3_jrd_addr", {24'h0, ram_address}, 32'h00);
        chk("t3_wait_c1", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        @(negedge clk);
        chk("t3_wait_c2", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        @(negedge clk);
        chk("t3_wait_c3", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        chk("t3_mon", MonDReg, 32'h00001111);
        @(negedge clk);
        chk("t3_wait_c4", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        chk("t3_crd_addr", {24'h0, ram_address}, 32'h20);
        @(negedge clk);
        chk("t3_wait_c5", {31'h0, cpu_if.cpu_waitrequest}, 32'h0);
        chk("t3_rdata", cpu_if.cpu_readdata, 32'hA5A50020);
        cpu_if.cpu_read = 1'b0;
        @(negedge clk);
        // solo JTAG write at 0x01 makes JTAG the last grant
        pulse_b(32'h0BADF00D);
        chk("t3_solo_addr", {24'h0, ram_address}, 32'h01);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        cpu_if.cpu_address   = 8'h21;
        cpu_if.cpu_writedata = 32'h00000077;
        cpu_if.cpu_write     = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        chk("t3_rr_cpu_wren", {31'h0, ram_wren}, 32'h1);
        chk("t3_rr_cpu_addr", {24'h0, ram_address}, 32'h21);
        chk("t3_rr_cpu_wait", {31'h0, cpu_if.cpu_waitrequest}, 32'h0);
        cpu_if.cpu_write = 1'b0;
        @(negedge clk);
        chk("t3_rr_idle_rden", {31'h0, ram_rden}, 32'h0);
        @(negedge clk);
        chk("t3_rr_jrd_rden", {31'h0, ram_rden}, 32'h1);
        chk("t3_rr_jrd_addr", {24'h0, ram_address}, 32'h02);
        @(negedge clk);
        @(negedge clk);
        chk("t3_rr_mon", MonDReg, 32'h22222222);
        chk("t3_mem01", mem[8'h01], 32'h0BADF00D);
        chk("t3_mem21", mem[8'h21], 32'h00000077);

        // 4: overrun
        w0 = n_wr;
        r0 = n_rd;
        pulse_b(32'h5555AAAA);
        pulse_r();
        chk("t4_ovr_set", {31'h0, jtag_overrun}, 32'h1);
        chk("t4_ready", {31'h0, monitor_ready}, 32'h1);
        repeat (3) @(negedge clk);
        chk("t4_wr_count", n_wr - w0, 32'd1);
        chk("t4_rd_count", n_rd - r0, 32'd0);
        chk("t4_mem03", mem[8'h03], 32'h5555AAAA);
        chk("t4_ovr_sticky", {31'h0, jtag_overrun}, 32'h1);
        pulse_a(8'hFF);
        chk("t4_ovr_clr", {31'h0, jtag_overrun}, 32'h0);

        // 5: pointer wrap
        pulse_b(32'h11110000);
        chk("t5_addr_ff", {24'h0, ram_address}, 32'hFF);
        @(negedge clk);
        pulse_b(32'h22220001);
        chk("t5_addr_wrap", {24'h0, ram_address}, 32'h00);
        @(negedge clk);
        chk("t5_memff", mem[8'hFF], 32'h11110000);
        chk("t5_mem00", mem[8'h00], 32'h22220001);

        // 6: reset during a CPU read
        cpu_if.cpu_address = 8'h20;
        cpu_if.cpu_read    = 1'b1;
        @(negedge clk);
        chk("t6_crd_rden", {31'h0, ram_rden}, 32'h1);
        #2 reset_n = 1'b0;
        #1;
        chk("t6_rst_rden", {31'h0, ram_rden}, 32'h0);
        chk("t6_rst_addr", {24'h0, ram_address}, 32'h0);
        chk("t6_rst_wdata", ram_wdata, 32'h0);
        chk("t6_rst_mon", MonDReg, 32'h0);
        chk("t6_rst_ready", {31'h0, monitor_ready}, 32'h0);
        chk("t6_rst_wait", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk("t6_re_rden", {31'h0, ram_rden}, 32'h1);
        chk("t6_re_wait", {31'h0, cpu_if.cpu_waitrequest}, 32'h1);
        @(negedge clk);
        chk("t6_done_wait", {31'h0, cpu_if.cpu_waitrequest}, 32'h0);
        chk("t6_rdata", cpu_if.cpu_readdata, 32'hA5A50020);
        cpu_if.cpu_read = 1'b0;
        @(negedge clk);

        chk("rden_wren_exclusive", {31'h0, both_seen}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
